mips_writeback_pipeline: RTL and testbench

//  Back end of the pipelined datapath: carries register write requests from EX through MEM to WB.
//  It drives the register file write port (wrEnable/wrAddr/wrData).
//  It also resolves forwarding for the register file read ports (rd1/rd2) and flags load-use hazards.
//  It sits between the EX-stage control/ALU outputs and the register file.

---
 rtl/mips_writeback_pkg.sv | 35 +++
 rtl/mips_writeback_fwd_mux.sv | 48 ++++
 rtl/mips_writeback_pipeline.sv | 128 ++++++++++++
 tb/tb_mips_writeback_pipeline.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_writeback_pkg.sv
// Shared types for the writeback back end: word/register types, write-data source
// encoding, the clock/reset bundle, the default-width pipeline slot and its accessor macros.
package mips_writeback_pkg;

   localparam int MIPS_WORD_W     = 32;
   localparam int MIPS_REG_ADDR_W = 5;

   typedef logic [MIPS_WORD_W-1:0]     Word_T;
   typedef logic [MIPS_REG_ADDR_W-1:0] RegAddr_T;

   // Code 11 is reserved and behaves exactly like ALU.
   typedef enum logic [1:0] {
      WDS_ALU  = 2'b00,
      WDS_MEM  = 2'b01,
      WDS_LINK = 2'b10,
      WDS_RSVD = 2'b11
   } WriteDataSource_T;

   typedef struct packed {
      logic clk;
      logic rst_n;
   } Data_Control_Control_T;

   typedef struct packed {
      logic             valid;
      logic             wen;
      RegAddr_T         addr;
      WriteDataSource_T src;
      Word_T            data;
   } Slot_T;

endpackage

`define MIPS_SLOT_WRITES(s) ((s).valid & (s).wen)
`define MIPS_SLOT_IS_LOAD(s) ((s).src == mips_writeback_pkg::WDS_MEM)

// File: rtl/mips_writeback_fwd_mux.sv
// One register-file read port: picks the youngest in-flight writer or flags a hazard.
// With MIPS_WB_FORWARD_EN undefined, any pending writer to the port raises a hazard instead.
module mips_writeback_fwd_mux
   import mips_writeback_pkg::*;
#(
   parameter int WORD_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rd_addr,
   input  logic [WORD_W-1:0]     rd_data,
   input  logic                  m_wen,
   input  logic [REG_ADDR_W-1:0] m_addr,
   input  logic                  w_wen,
   input  logic [REG_ADDR_W-1:0] w_addr,
`ifdef MIPS_WB_FORWARD_EN
   input  WriteDataSource_T      m_src,
   input  logic [WORD_W-1:0]     m_data,
   input  logic [WORD_W-1:0]     w_data,
`endif
   output logic [WORD_W-1:0]     fwd_data,
   output logic                  hazard
);

   logic m_hit;
   logic w_hit;

   assign m_hit = m_wen && (m_addr == rd_addr);
   assign w_hit = w_wen && (w_addr == rd_addr);

   always_comb begin
      fwd_data = rd_data;
      hazard   = 1'b0;
      // $0 reads are hardwired zero in the register file, so they never need help.
      if (rd_addr != '0) begin
`ifdef MIPS_WB_FORWARD_EN
         if (m_hit) begin
            if (m_src == WDS_MEM) hazard   = 1'b1;
            else                  fwd_data = m_data;
         end else if (w_hit) begin
            fwd_data = w_data;
         end
`else
         hazard = m_hit | w_hit;
`endif
      end
   end

endmodule

// File: rtl/mips_writeback_pipeline.sv
// EX->M->W register-write pipeline driving the register file write port, plus read-port
// forwarding/hazard resolution. Forwarding is enabled by defining MIPS_WB_FORWARD_EN.
module mips_writeback_pipeline
   import mips_writeback_pkg::*;
#(
   parameter int                WORD_W      = 32,
   parameter int                REG_ADDR_W  = 5,
   parameter logic [WORD_W-1:0] LINK_OFFSET = 8
) (
   input  Data_Control_Control_T   ctrl,
   input  logic                    stall,
   input  logic                    flush,
   input  logic                    exValid,
   input  logic                    exWrEnable,
   input  logic [REG_ADDR_W-1:0]   exWrAddr,
   input  logic [1:0]              exWrSource,
   input  logic [WORD_W-1:0]       exAluResult,
   input  logic [WORD_W-1:0]       exPcAddr,
   input  logic [WORD_W-1:0]       memOut,
   input  logic [REG_ADDR_W-1:0]   rd1Addr,
   input  logic [REG_ADDR_W-1:0]   rd2Addr,
   input  logic [WORD_W-1:0]       rd1Data,
   input  logic [WORD_W-1:0]       rd2Data,
   output logic                    wrEnable,
   output logic [REG_ADDR_W-1:0]   wrAddr,
   output logic [WORD_W-1:0]       wrData,
   output logic [WORD_W-1:0]       fwd1Data,
   output logic [WORD_W-1:0]       fwd2Data,
   output logic                    hazard
);

   typedef struct packed {
      logic                  valid;
      logic                  wen;
      logic [REG_ADDR_W-1:0] addr;
      WriteDataSource_T      src;
      logic [WORD_W-1:0]     data;
   } slot_t;

   logic  clk;
   logic  rst_n;
   slot_t ex_slot;
   slot_t m_d, m_q;
   slot_t w_d, w_q;
   logic  m_wen, w_wen;
   logic  hazard1, hazard2;

   assign clk   = ctrl.clk;
   assign rst_n = ctrl.rst_n;

   always_comb begin
      ex_slot       = '0;
      ex_slot.valid = exValid;
      // Writes to $0 are dropped here so nothing downstream ever matches them.
      ex_slot.wen   = exValid & exWrEnable & (exWrAddr != '0);
      ex_slot.addr  = exWrAddr;
      ex_slot.src   = WriteDataSource_T'(exWrSource);
      ex_slot.data  = (ex_slot.src == WDS_LINK) ? exPcAddr + LINK_OFFSET : exAluResult;
   end

   always_comb begin
      m_d = m_q;
      w_d = w_q;
      if (!stall) begin
         w_d = m_q;
         if (`MIPS_SLOT_IS_LOAD(m_q)) w_d.data = memOut;
         m_d = ex_slot;
      end
      // A flush bubbles M even while stalled; W is governed by stall alone.
      if (flush) m_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q <= '0;
         w_q <= '0;
      end else begin
         m_q <= m_d;
         w_q <= w_d;
      end
   end

   assign m_wen    = `MIPS_SLOT_WRITES(m_q);
   assign w_wen    = `MIPS_SLOT_WRITES(w_q);
   assign wrEnable = w_wen;
   assign wrAddr   = w_q.addr;
   assign wrData   = w_q.data;
   assign hazard   = hazard1 | hazard2;

   mips_writeback_fwd_mux #(
      .WORD_W     (WORD_W),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_fwd1 (
      .rd_addr  (rd1Addr),
      .rd_data  (rd1Data),
      .m_wen    (m_wen),
      .m_addr   (m_q.addr),
      .w_wen    (w_wen),
      .w_addr   (w_q.addr),
`ifdef MIPS_WB_FORWARD_EN
      .m_src    (m_q.src),
      .m_data   (m_q.data),
      .w_data   (w_q.data),
`endif
      .fwd_data (fwd1Data),
      .hazard   (hazard1)
   );

   mips_writeback_fwd_mux #(
      .WORD_W     (WORD_W),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_fwd2 (
      .rd_addr  (rd2Addr),
      .rd_data  (rd2Data),
      .m_wen    (m_wen),
      .m_addr   (m_q.addr),
      .w_wen    (w_wen),
      .w_addr   (w_q.addr),
`ifdef MIPS_WB_FORWARD_EN
      .m_src    (m_q.src),
      .m_data   (m_q.data),
      .w_data   (w_q.data),
`endif
      .fwd_data (fwd2Data),
      .hazard   (hazard2)
   );

endmodule

// File: tb/tb_mips_writeback_pipeline.sv
// Scoreboard bench for mips_writeback_pipeline: directed scenarios followed by random traffic,
// checked every cycle against an instruction-level reference model.
module tb_mips_writeback_pipeline;
   import mips_writeback_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst_n;
   Data_Control_Control_T ctrl;
   logic        stall, flush, exValid, exWrEnable;
   logic [4:0]  exWrAddr, rd1Addr, rd2Addr;
   logic [1:0]  exWrSource;
   logic [31:0] exAluResult, exPcAddr, memOut, rd1Data, rd2Data;
   logic        wrEnable, hazard;
   logic [4:0]  wrAddr;
   logic [31:0] wrData, fwd1Data, fwd2Data;

   int checks = 0;
   int errors = 0;

   assign ctrl.clk   = clk;
   assign ctrl.rst_n = rst_n;
   always #5 clk = ~clk;

   mips_writeback_pipeline dut (
      .ctrl(ctrl), .stall(stall), .flush(flush), .exValid(exValid), .exWrEnable(exWrEnable),
      .exWrAddr(exWrAddr), .exWrSource(exWrSource), .exAluResult(exAluResult),
      .exPcAddr(exPcAddr), .memOut(memOut), .rd1Addr(rd1Addr), .rd2Addr(rd2Addr),
      .rd1Data(rd1Data), .rd2Data(rd2Data), .wrEnable(wrEnable), .wrAddr(wrAddr),
      .wrData(wrData), .fwd1Data(fwd1Data), .fwd2Data(fwd2Data), .hazard(hazard)
   );

   typedef struct {
      bit rst_n, stall, flush, v, we;
      logic [4:0]  addr, r1a, r2a;
      logic [1:0]  src;
      logic [31:0] alu, pc, mem, r1d, r2d;
   } stim_t;

   // An instruction as the register file will eventually see it.
   typedef struct {
      bit          wen;
      logic [4:0]  addr;
      logic [1:0]  src;
      logic [31:0] data;
   } instr_t;

   typedef struct {
      logic        wen, hz;
      logic [4:0]  addr;
      logic [31:0] data, f1, f2;
      bit          f1_care, f2_care;
   } exp_t;

   exp_t   exp_q[$];
   instr_t inflight[$];   // [0] = younger (just left EX), [1] = older (being written back)

   function automatic instr_t bubble();
      instr_t b;
      b.wen = 0; b.addr = '0; b.src = '0; b.data = '0;
      return b;
   endfunction

   function automatic void model_clear();
      inflight = {bubble(), bubble()};
   endfunction

   function automatic instr_t issue_from_ex();
      instr_t n;
      n.wen  = exValid && exWrEnable && (exWrAddr != 0);
      n.addr = exWrAddr;
      n.src  = exWrSource;
      n.data = (exWrSource == 2'b10) ? 32'(exPcAddr + 32'd8) : exAluResult;
      return n;
   endfunction

   // Advance the model across one clock edge using the inputs that were present at it.
   function automatic void model_clock();
      instr_t retiring;
      if (!rst_n) begin
         model_clear();
         return;
      end
      if (!stall) begin
         retiring = inflight[0];
         if (retiring.src == 2'b01) retiring.data = memOut;
         inflight[1] = retiring;
         inflight[0] = flush ? bubble() : issue_from_ex();
      end else if (flush) begin
         inflight[0] = bubble();
      end
   endfunction

   function automatic void port_expect(input logic [4:0] a, input logic [31:0] raw,
                                       output logic [31:0] f, output bit care, output logic hz);
      f = raw; care = 1; hz = 1'b0;
      if (a == 0) return;
`ifdef MIPS_WB_FORWARD_EN
      for (int i = 0; i < 2; i++) begin
         if (inflight[i].wen && inflight[i].addr == a) begin
            if (i == 0 && inflight[i].src == 2'b01) begin
               hz = 1'b1; care = 0;
            end else begin
               f = inflight[i].data;
            end
            return;
         end
      end
`else
      for (int i = 0; i < 2; i++)
         if (inflight[i].wen && inflight[i].addr == a) hz = 1'b1;
`endif
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s.rst_n = 1; s.stall = 0; s.flush = 0; s.v = 0; s.we = 0;
      s.addr = '0; s.src = '0; s.alu = '0; s.pc = '0; s.mem = '0;
      s.r1a = '0; s.r2a = '0; s.r1d = 32'h1111_1111; s.r2d = 32'h2222_2222;
      return s;
   endfunction

   function automatic stim_t wr(input logic [4:0] a, input logic [1:0] src, input logic [31:0] alu);
      stim_t s = idle();
      s.v = 1; s.we = 1; s.addr = a; s.src = src; s.alu = alu; s.pc = 32'h0000_0100;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s.rst_n = ($urandom_range(0, 99) != 0);
      s.stall = ($urandom_range(0, 4) == 0);
      s.flush = ($urandom_range(0, 9) == 0);
      s.v     = ($urandom_range(0, 5) != 0);
      s.we    = ($urandom_range(0, 4) != 0);
      s.addr  = 5'($urandom_range(0, 4));
      s.src   = 2'($urandom_range(0, 3));
      s.alu   = $urandom; s.pc = $urandom; s.mem = $urandom;
      s.r1a   = 5'($urandom_range(0, 4));
      s.r2a   = 5'($urandom_range(0, 4));
      s.r1d   = $urandom; s.r2d = $urandom;
      return s;
   endfunction

   task automatic step(input stim_t s);
      exp_t e;
      logic h1, h2;
      @(posedge clk);
      model_clock();
      #1;
      rst_n = s.rst_n; stall = s.stall; flush = s.flush; exValid = s.v; exWrEnable = s.we;
      exWrAddr = s.addr; exWrSource = s.src; exAluResult = s.alu; exPcAddr = s.pc;
      memOut = s.mem; rd1Addr = s.r1a; rd2Addr = s.r2a; rd1Data = s.r1d; rd2Data = s.r2d;
      if (!rst_n) model_clear();
      e.wen  = inflight[1].wen;
      e.addr = inflight[1].addr;
      e.data = inflight[1].data;
      port_expect(rd1Addr, rd1Data, e.f1, e.f1_care, h1);
      port_expect(rd2Addr, rd2Data, e.f2, e.f2_care, h2);
      e.hz = h1 | h2;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wrEnable", 32'(wrEnable), 32'(e.wen));
            chk("wrAddr",   32'(wrAddr),   32'(e.addr));
            chk("wrData",   wrData,        e.data);
            chk("hazard",   32'(hazard),   32'(e.hz));
            if (e.f1_care) chk("fwd1Data", fwd1Data, e.f1);
            if (e.f2_care) chk("fwd2Data", fwd2Data, e.f2);
         end
      end
   end

   initial begin : driver
      stim_t s;
      stim_t r;
      rst_n = 1'b1;
      stall = 0; flush = 0; exValid = 0; exWrEnable = 0; exWrAddr = '0; exWrSource = '0;
      exAluResult = '0; exPcAddr = '0; memOut = '0; rd1Addr = '0; rd2Addr = '0;
      rd1Data = '0; rd2Data = '0;
      model_clear();
      #1 rst_n = 1'b0;
      r = idle(); r.rst_n = 0;
      repeat (3) step(r);

      // ALU write lands two cycles later.
      step(wr(5'd5, 2'b00, 32'h0000_1234));
      repeat (3) step(idle());

      // Load followed by a dependent read while the load sits in M.
      step(wr(5'd7, 2'b01, 32'h0000_0040));
      s = idle(); s.mem = 32'hDEAD_BEEF; s.r1a = 5'd7; step(s);
      repeat (2) step(idle());

      // Two writers to the same register; the younger one must win.
      step(wr(5'd3, 2'b00, 32'd1));
      step(wr(5'd3, 2'b00, 32'd2));
      s = idle(); s.r2a = 5'd3; step(s);
      s = idle(); s.r1a = 5'd3; s.r2a = 5'd3; step(s);

      // $0 write is dropped; link write wraps.
      step(wr(5'd0, 2'b00, 32'hFFFF_FFFF));
      s = wr(5'd31, 2'b10, 32'h0); s.pc = 32'hFFFF_FFFC; step(s);
      s = idle(); s.r1a = 5'd0; s.r2a = 5'd31; step(s);
      repeat (2) step(idle());

      // Stall holds the write port; flush squashes; reset mid-stall drops everything.
      step(wr(5'd9, 2'b00, 32'hCAFE_0009));
      step(wr(5'd10, 2'b00, 32'hCAFE_000A));
      s = idle(); s.stall = 1; repeat (3) step(s);
      s = wr(5'd11, 2'b00, 32'hCAFE_000B); s.stall = 1; s.flush = 1; step(s);
      s = wr(5'd12, 2'b00, 32'hCAFE_000C); s.flush = 1; step(s);
      repeat (3) step(idle());
      step(wr(5'd13, 2'b00, 32'h1313_1313));
      s = wr(5'd14, 2'b00, 32'h1414_1414); s.stall = 1; step(s);
      s = idle(); s.stall = 1; step(s);
      s.rst_n = 0; step(s);
      repeat (2) step(idle());

      repeat (400) step(rand_stim());
      repeat (2) step(idle());

      repeat (10) begin
         if (exp_q.size() != 0) @(negedge clk);
      end
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
